// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad entry controller.
//  - key codes for the command keys
//  - scan and entry state encodings
//  - register file write interface widths
//  - key_map(): (row, col) position to key code
package keypad_pkg;

    localparam int DIGIT_W   = 4;
    localparam int OPERAND_W = 16;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    typedef enum logic [1:0] {
        SC_SCAN,
        SC_DEBOUNCE,
        SC_PRESSED,
        SC_RELEASE
    } scan_state_t;

    typedef enum logic [2:0] {
        EN_IDLE,
        EN_SH_T,
        EN_SH_O,
        EN_COMMIT,
        EN_CLR_T,
        EN_CLR_O
    } entry_state_t;

    // Layout  r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'h0;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// keypad_entry_ctrl_if: keypad matrix and register file write signals.
//  row       keypad rows, active-low (driven by the keypad)
//  col       keypad column drive, active-low
//  Din       digit value to the register file
//  level     0 = ones slot, 1 = tens slot
//  WE        one-cycle commit strobe
//  W1        operand select for the commit
//  key_valid one-cycle pulse per debounced press
//  key_code  code of the last debounced key
// master = controller side, slave = keypad / register file side.
interface keypad_entry_ctrl_if;
    logic [3:0]                   row;
    logic [3:0]                   col;
    logic [keypad_pkg::DIGIT_W-1:0] Din;
    logic                         level;
    logic                         WE;
    logic                         W1;
    logic                         key_valid;
    logic [3:0]                   key_code;

    modport master (input row, output col, Din, level, WE, W1, key_valid, key_code);
    modport slave  (output row, input col, Din, level, WE, W1, key_valid, key_code);
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: stable-count filter shared by the press and release phases.
//  CLK, RST      clock, asynchronous active-high reset
//  clr           clear the run counter
//  pattern       sampled row pattern
//  ref_pat       pattern that must be held
//  stable        pattern has matched ref_pat for DEBOUNCE_CNT consecutive cycles
//  changed       pattern differs from ref_pat this cycle (also clears the count)
module keypad_debounce #(
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       clr,
    input  logic [3:0] pattern,
    input  logic [3:0] ref_pat,
    output logic       stable,
    output logic       changed
);
    localparam int CW = $clog2(DEBOUNCE_CNT);

    logic [CW-1:0] cnt;

    assign changed = (pattern != ref_pat);
    // The current matching cycle is the last one needed when cnt reaches CNT-1.
    assign stable  = !changed && (cnt == CW'(DEBOUNCE_CNT - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            cnt <= '0;
        else if (clr || changed)
            cnt <= '0;
        else if (!stable)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: scans and debounces a 4x4 keypad and turns digit, ENTER
// and CLEAR keys into register file writes (2-digit calculator-style shift).
//  CLK   system clock, RST asynchronous active-high reset
//  bus   keypad_entry_ctrl_if.master: row in; col, Din, level, WE, W1,
//        key_valid, key_code out
// Build option: KEYPAD_AUTO_COMMIT_EN commits automatically after the second
// digit since the last commit/clear.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic CLK,
    input  logic RST,
    keypad_entry_ctrl_if.master bus
);
    localparam int DW = $clog2(SCAN_DIV);

    logic [3:0]    row_m, row_s;
    scan_state_t   sc_q, sc_d;
    logic [DW-1:0] div_q;
    logic [3:0]    col_q, pat_q, kcode_q, ref_pat, low;
    logic [1:0]    r_idx, c_idx;
    logic          db_clr, db_stable, db_changed, multi_low, key_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_m <= '1;
            row_s <= '1;
        end else begin
            row_m <= bus.row;
            row_s <= row_m;
        end
    end

    assign low       = ~row_s;
    assign multi_low = |(low & (low - 4'd1));

    always_comb begin
        r_idx = '0;
        c_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!pat_q[i]) r_idx = 2'(i);
            if (!col_q[i]) c_idx = 2'(i);
        end
    end

    keypad_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (db_clr),
        .pattern (row_s),
        .ref_pat (ref_pat),
        .stable  (db_stable),
        .changed (db_changed)
    );

    always_comb begin
        sc_d    = sc_q;
        db_clr  = 1'b0;
        ref_pat = pat_q;
        case (sc_q)
            SC_SCAN: begin
                db_clr = 1'b1;
                if (row_s != 4'hF) sc_d = SC_DEBOUNCE;
            end
            SC_DEBOUNCE: begin
                if (db_changed || multi_low) sc_d = SC_SCAN;
                else if (db_stable)          sc_d = SC_PRESSED;
            end
            SC_PRESSED: begin
                db_clr = 1'b1;
                sc_d   = SC_RELEASE;
            end
            SC_RELEASE: begin
                ref_pat = 4'hF;
                if (db_stable) sc_d = SC_SCAN;
            end
            default: sc_d = SC_SCAN;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sc_q    <= SC_SCAN;
            col_q   <= 4'b1110;
            div_q   <= '0;
            pat_q   <= '1;
            kcode_q <= '0;
        end else begin
            sc_q <= sc_d;
            if (sc_q == SC_SCAN) begin
                if (row_s != 4'hF) begin
                    pat_q <= row_s;
                    div_q <= '0;
                end else if (div_q == DW'(SCAN_DIV - 1)) begin
                    div_q <= '0;
                    col_q <= {col_q[2:0], col_q[3]};
                end else begin
                    div_q <= div_q + 1'b1;
                end
            end
            if (sc_q == SC_DEBOUNCE && sc_d == SC_PRESSED)
                kcode_q <= key_map(r_idx, c_idx);
        end
    end

    assign key_valid = (sc_q == SC_PRESSED);

    entry_state_t en_q, en_d;
    logic [3:0]   din_q, din_d, ones_q, ones_d;
    logic         level_q, level_d, we_q, we_d, w1_q, w1_d;
`ifdef KEYPAD_AUTO_COMMIT_EN
    logic [1:0]   dcnt_q, dcnt_d;
`endif

    always_comb begin
        en_d    = en_q;
        din_d   = din_q;
        level_d = level_q;
        we_d    = 1'b0;
        w1_d    = w1_q;
        ones_d  = ones_q;
`ifdef KEYPAD_AUTO_COMMIT_EN
        dcnt_d  = dcnt_q;
`endif
        case (en_q)
            EN_IDLE: begin
                if (key_valid) begin
                    if (kcode_q <= 4'd9)           en_d = EN_SH_T;
                    else if (kcode_q == KEY_ENTER) en_d = EN_COMMIT;
                    else if (kcode_q == KEY_CLEAR) en_d = EN_CLR_T;
                end
            end
            EN_SH_T: en_d = EN_SH_O;
`ifdef KEYPAD_AUTO_COMMIT_EN
            EN_SH_O: en_d = (dcnt_q == 2'd2) ? EN_COMMIT : EN_IDLE;
`else
            EN_SH_O: en_d = EN_IDLE;
`endif
            EN_COMMIT: begin
                en_d   = EN_IDLE;
                w1_d   = ~w1_q;
                ones_d = '0;
            end
            EN_CLR_T: en_d = EN_CLR_O;
            EN_CLR_O: en_d = EN_IDLE;
            default:  en_d = EN_IDLE;
        endcase
        // Outputs are registered, so they are loaded with the values of the
        // state being entered and line up exactly with that state's cycle.
        case (en_d)
            EN_SH_T: begin
                level_d = 1'b1;
                din_d   = ones_q;
            end
            EN_SH_O: begin
                level_d = 1'b0;
                din_d   = kcode_q;
                ones_d  = kcode_q;
`ifdef KEYPAD_AUTO_COMMIT_EN
                dcnt_d  = dcnt_q + 2'd1;
`endif
            end
            EN_COMMIT: begin
                we_d = 1'b1;
`ifdef KEYPAD_AUTO_COMMIT_EN
                dcnt_d = '0;
`endif
            end
            EN_CLR_T: begin
                level_d = 1'b1;
                din_d   = '0;
`ifdef KEYPAD_AUTO_COMMIT_EN
                dcnt_d  = '0;
`endif
            end
            EN_CLR_O: begin
                level_d = 1'b0;
                din_d   = '0;
                ones_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            en_q    <= EN_IDLE;
            din_q   <= '0;
            level_q <= 1'b0;
            we_q    <= 1'b0;
            w1_q    <= 1'b0;
            ones_q  <= '0;
`ifdef KEYPAD_AUTO_COMMIT_EN
            dcnt_q  <= '0;
`endif
        end else begin
            en_q    <= en_d;
            din_q   <= din_d;
            level_q <= level_d;
            we_q    <= we_d;
            w1_q    <= w1_d;
            ones_q  <= ones_d;
`ifdef KEYPAD_AUTO_COMMIT_EN
            dcnt_q  <= dcnt_d;
`endif
        end
    end

    assign bus.col       = col_q;
    assign bus.Din       = din_q;
    assign bus.level     = level_q;
    assign bus.WE        = we_q;
    assign bus.W1        = w1_q;
    assign bus.key_valid = key_valid;
    assign bus.key_code  = kcode_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: scoreboard bench for keypad_entry_ctrl.
// A keypad model drives the rows from the column drive; each key press pushes
// the expected output events (key pulse, slot writes, commit) into a queue and
// a monitor pops and compares them as the DUT produces them.
// Honours KEYPAD_AUTO_COMMIT_EN the same way as the design.
module tb_keypad_entry_ctrl;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int EV_KV    = 0;
    localparam int EV_WR    = 1;
    localparam int EV_WE    = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    keypad_entry_ctrl_if kif();

    keypad_entry_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (kif)
    );

    // Keypad layout, index r*4+c.
    logic [3:0] layout [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};
    logic       key_down = 1'b0;
    logic       glitch   = 1'b0;
    logic [1:0] key_r    = '0;
    logic [1:0] key_c    = '0;

    assign kif.row = glitch ? 4'b1101 :
                     (key_down && kif.col[key_c] == 1'b0) ? ~(4'b0001 << key_r) : 4'hF;

    typedef struct { int kind; int a; int b; } ev_t;
    ev_t expq[$];
    int  tests = 0;
    int  fails = 0;

    // Reference model: register file temp slots, digit shadow, operand select.
    int slot1 = 0, slot0 = 0, shadow = 0, op = 0, ndig = 0;
    // Register file as seen by the monitor.
    int mon_t1 = 0, mon_t0 = 0;
    int mon_rf [2] = '{0, 0};

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic check_ev(input int kind, input int a, input int b);
        ev_t e;
        tests++;
        if (expq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d, required none", kind, a, b);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind || e.a != a || e.b != b) begin
                fails++;
                $display("FAIL event: got kind=%0d a=%0d b=%0d, required kind=%0d a=%0d b=%0d",
                         kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    task automatic model_commit();
        expq.push_back('{EV_WE, op, slot1 * 10 + slot0});
        op     = 1 - op;
        shadow = 0;
        ndig   = 0;
    endtask

    task automatic model_key(input int code);
        expq.push_back('{EV_KV, 0, code});
        if (code <= 9) begin
            expq.push_back('{EV_WR, 1, shadow});
            expq.push_back('{EV_WR, 0, code});
            slot1  = shadow;
            slot0  = code;
            shadow = code;
`ifdef KEYPAD_AUTO_COMMIT_EN
            ndig++;
            if (ndig == 2) model_commit();
`endif
        end else if (code == 10) begin
            model_commit();
        end else if (code == 12) begin
            expq.push_back('{EV_WR, 1, 0});
            expq.push_back('{EV_WR, 0, 0});
            slot1  = 0;
            slot0  = 0;
            shadow = 0;
            ndig   = 0;
        end
    endtask

    task automatic set_key(input int code);
        for (int i = 0; i < 16; i++)
            if (int'(layout[i]) == code) begin
                key_r = 2'(i / 4);
                key_c = 2'(i % 4);
            end
    endtask

    task automatic press(input int code, input int hold, input int gap);
        set_key(code);
        model_key(code);
        key_down = 1'b1;
        repeat (hold) @(negedge CLK);
        key_down = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    // Monitor: turns DUT outputs into events and checks them against the queue.
    initial begin : monitor
        logic [4:0] prev;
        prev = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev = '0;
            end else begin
                if (kif.key_valid)
                    check_ev(EV_KV, 0, int'(kif.key_code));
                if ({kif.level, kif.Din} != prev) begin
                    check_ev(EV_WR, int'(kif.level), int'(kif.Din));
                    if (kif.level) mon_t1 = int'(kif.Din);
                    else           mon_t0 = int'(kif.Din);
                end
                if (kif.WE) begin
                    check_ev(EV_WE, int'(kif.W1), mon_t1 * 10 + mon_t0);
                    mon_rf[kif.W1] = mon_t1 * 10 + mon_t0;
                end
                prev = {kif.level, kif.Din};
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no end of run, required $finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [3:0] ec, seen;
        int         waited;

        // Reset and idle scan.
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            ec = ~(4'b0001 << ((i / 4) % 4));
            chk("reset_scan_col", int'(kif.col), int'(ec));
        end
        chk("reset_din", int'(kif.Din), 0);
        chk("reset_level", int'(kif.level), 0);
        chk("reset_we", int'(kif.WE), 0);
        chk("reset_w1", int'(kif.W1), 0);
        chk("reset_key_code", int'(kif.key_code), 0);

        // Long hold of key 5: a single pulse only.
        press(5, 140, 20);
        press(12, 60, 20);

        // Short glitch: no press, scanning resumes.
        glitch = 1'b1;
        repeat (3) @(negedge CLK);
        glitch = 1'b0;
        repeat (10) @(negedge CLK);
        seen = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            seen = seen | ~kif.col;
        end
        chk("glitch_scan_resumes", int'(seen), 15);

        // 4, 2, ENTER -> RF[0] = 42.
        press(4, 60, 20);
        press(2, 60, 20);
        press(10, 60, 20);
        chk("rf0_value", mon_rf[0], 42);
        chk("w1_after_enter", int'(kif.W1), op);

        // 7, 3, 9 then CLEAR.
        press(7, 60, 20);
        press(3, 60, 20);
        press(9, 60, 20);
        press(12, 60, 20);
        chk("w1_after_clear", int'(kif.W1), op);

        // Random keys.
        for (int n = 0; n < 30; n++)
            press(int'($urandom_range(0, 15)), 60 + int'($urandom_range(0, 60)),
                  16 + int'($urandom_range(0, 20)));
        chk("w1_after_random", int'(kif.W1), op);

        // Reset during SH_T.
        if (op == 0) press(10, 60, 20);
        set_key(8);
        expq.push_back('{EV_KV, 0, 8});
        key_down = 1'b1;
        waited = 0;
        while (!kif.key_valid && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        chk("rst_test_press_seen", int'(kif.key_valid), 1);
        @(posedge CLK);
        #1;
        RST      = 1'b1;
        key_down = 1'b0;
        @(negedge CLK);
        chk("midrst_col", int'(kif.col), 14);
        chk("midrst_din", int'(kif.Din), 0);
        chk("midrst_level", int'(kif.level), 0);
        chk("midrst_we", int'(kif.WE), 0);
        chk("midrst_w1", int'(kif.W1), 0);
        chk("midrst_key_valid", int'(kif.key_valid), 0);
        chk("midrst_key_code", int'(kif.key_code), 0);
        chk("midrst_queue_empty", expq.size(), 0);
        expq.delete();
        shadow = 0;
        op     = 0;
        ndig   = 0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // 1, 2: commits on its own only with auto commit.
        press(1, 60, 20);
        press(2, 60, 20);
        chk("w1_after_12", int'(kif.W1), op);

        repeat (40) @(negedge CLK);
        chk("queue_drained", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
